// File: rtl/usb_rx_packet_assembler.sv
// Assembles one USB packet (PID + up to MAX_BYTES bytes) per receive burst, checks
// the CRC16 of DATA packets and holds the result behind a valid/ack handshake.
module usb_rx_packet_assembler #(
    parameter int MAX_BYTES = 66
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         rx_active,
    input  logic         new_byte,
    input  logic [7:0]   rx_data,
    input  logic         pkt_ack,
    output logic         pkt_valid,
    output logic [3:0]   pkt_pid,
    output logic [511:0] pkt_data,
    output logic [6:0]   pkt_len,
    output logic         crc_ok,
    output logic         pid_err,
    output logic         overflow,
    output logic         drop
);

    localparam int          OUT_BYTES    = (MAX_BYTES < 64) ? MAX_BYTES : 64;
    localparam logic [6:0]  MAX_CNT      = 7'(MAX_BYTES);
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUAL = 16'hB001;

    typedef enum logic [1:0] {
        IDLE,
        PID,
        DATA,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        new_byte_d;
    logic        byte_acc;
    logic [6:0]  cnt;
    logic [15:0] crc;
    logic [7:0]  buf_q [MAX_BYTES];

    logic        load_pid;
    logic        data_byte;
    logic        finish;
    logic        take_ack;
    logic        set_drop;
    logic        is_data;
    logic [6:0]  len_calc;
    logic        crc_ok_calc;

    // Reflected CRC16 (poly 0x8005), one byte processed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++)
            c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'hA001 : 16'h0000);
        return c;
    endfunction

    assign byte_acc = new_byte & ~new_byte_d;
    assign is_data  = (pkt_pid[1:0] == 2'b11);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load_pid   = 1'b0;
        data_byte  = 1'b0;
        finish     = 1'b0;
        take_ack   = 1'b0;
        set_drop   = 1'b0;
        case (state)
            IDLE: begin
                // An ack wins over a coinciding burst start; that burst is taken next cycle.
                if (pkt_valid && pkt_ack)
                    take_ack = 1'b1;
                else if (rx_active) begin
                    if (pkt_valid) set_drop   = 1'b1;
                    else           state_next = PID;
                end
            end
            PID: begin
                if (byte_acc) begin
                    load_pid   = 1'b1;
                    state_next = DATA;
                end else if (!rx_active) begin
                    state_next = IDLE;
                end
            end
            DATA: begin
                data_byte = byte_acc;
                if (!rx_active) state_next = DONE;
            end
            DONE: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        if (is_data) begin
            len_calc    = (cnt < 7'd2) ? 7'd0 : cnt - 7'd2;
            crc_ok_calc = (cnt >= 7'd2) && (crc == CRC_RESIDUAL);
        end else begin
            len_calc    = cnt;
            crc_ok_calc = 1'b1;
        end
    end

    // NOTE: the byte buffer is reset and cleared on ack like any other state, so stale
    // payload never leaks into a later, shorter packet.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            new_byte_d <= 1'b0;
            pkt_pid    <= 4'd0;
            pid_err    <= 1'b0;
            cnt        <= 7'd0;
            crc        <= CRC_INIT;
            overflow   <= 1'b0;
            pkt_valid  <= 1'b0;
            pkt_len    <= 7'd0;
            crc_ok     <= 1'b0;
            drop       <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'd0;
        end else begin
            new_byte_d <= new_byte;
            if (load_pid) begin
                pkt_pid <= rx_data[3:0];
                pid_err <= (rx_data[7:4] != ~rx_data[3:0]);
                crc     <= CRC_INIT;
            end
            if (data_byte) begin
                crc <= crc16_byte(crc, rx_data);
                if (cnt < MAX_CNT) begin
                    buf_q[cnt] <= rx_data;
                    cnt        <= cnt + 7'd1;
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (finish) begin
                pkt_valid <= 1'b1;
                pkt_len   <= len_calc;
                crc_ok    <= crc_ok_calc;
            end
            if (set_drop) drop <= 1'b1;
            if (take_ack) begin
                pkt_valid <= 1'b0;
                drop      <= 1'b0;
                cnt       <= 7'd0;
                overflow  <= 1'b0;
                pkt_len   <= 7'd0;
                crc_ok    <= 1'b0;
                for (int i = 0; i < MAX_BYTES; i++) buf_q[i] <= 8'd0;
            end
        end
    end

    // Bytes at or beyond pkt_len (CRC bytes, unused slots) read as zero.
    always_comb begin
        pkt_data = '0;
        for (int k = 0; k < OUT_BYTES; k++)
            if (7'(k) < pkt_len) pkt_data[8*k +: 8] = buf_q[k];
    end

endmodule
